// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo
// Sample buffer between an upstream producer (valid/ready) and the 16-bit DAC
// serializer. Words are popped onto DATA16 on each serializer frame strobe once
// the FIFO has been prefilled. An empty FIFO at a frame strobe counts an
// underflow and sends the block back to prefill.
module dac_sample_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          PREFILL    = 8,
  parameter int          UF_MODE    = 0,
  parameter logic [15:0] MIDSCALE   = 16'h8000
) (
  input  logic                  CLK_100,
  input  logic                  RESET_N,
  input  logic [15:0]           S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic                  TR_CK,
  output logic [15:0]           DATA16,
  output logic [DEPTH_LOG2:0]   FILL,
  output logic                  PRIMED,
  output logic [15:0]           UF_CNT
);

  localparam int                  DEPTH       = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PREFILL_CNT = (DEPTH_LOG2 + 1)'(PREFILL);

  typedef enum logic {
    ST_PREFILL,
    ST_RUN
  } state_t;

  state_t                state, state_next;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_next;
  logic                  tr_q;
  logic                  adv, push, pop, underflow;
  logic                  s_ready_q;
  logic [15:0]           data_q;
  logic [15:0]           uf_cnt_q;

  // Frame strobe is the rising edge of TR_CK, acted on in the same cycle;
  // a push needs the registered ready so TR_CK never reaches S_READY.
  always_comb begin
    adv  = TR_CK & ~tr_q;
    push = S_VALID & s_ready_q;
  end

  // Next-state and pop/underflow decode; frame strobes do nothing in prefill.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    state_next = state;
    pop        = 1'b0;
    underflow  = 1'b0;
    case (state)
      ST_PREFILL: begin
        if (count >= PREFILL_CNT) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (adv) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            underflow  = 1'b1;
            state_next = ST_PREFILL;
          end
        end
      end
    endcase
  end

  // Occupancy after this edge; a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Control state: FSM, TR_CK history, pointers, occupancy and ready flag.
  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESET_N) begin
      state     <= ST_PREFILL;
      tr_q      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_next;
      tr_q      <= TR_CK;
      count     <= count_next;
      // Ready follows the post-edge count, so it can never be high while full.
      s_ready_q <= (count_next != FULL_CNT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage, written on every accepted push.
  always_ff @(posedge CLK_100) begin
    // NOTE: the storage array has no reset; reset empties the FIFO through the
    // pointers and count, and a reset array would only cost flops and routing.
    if (push) mem[wr_ptr] <= S_DATA;
  end

  // Output word: head of FIFO on a pop, optionally midscale on underflow.
  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q <= MIDSCALE;
    end else if (pop) begin
      data_q <= mem[rd_ptr];
    end else if (underflow && (UF_MODE != 0)) begin
      data_q <= MIDSCALE;
    end
  end

  // Underflow event counter, saturating at all-ones.
  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      uf_cnt_q <= '0;
    end else if (underflow && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign S_READY = s_ready_q;
  assign DATA16  = data_q;
  assign FILL    = count;
  assign PRIMED  = (state == ST_RUN);
  assign UF_CNT  = uf_cnt_q;

endmodule
